// File: rtl/fifo_read_arbiter.sv
// Round-robin burst scheduler sharing one FIFO read port among NREQ consumers; returned words
// appear RD_LAT+1 cycles after their rinc, tagged with the owner. An empty FIFO stalls the grant.
module fifo_read_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4,
  parameter int RD_LAT = 1,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [NREQ-1:0]   req_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_rdata_i,
  output logic              fifo_rinc_o,
  output logic [NREQ-1:0]   gnt_o,
  output logic              out_valid_o,
  output logic [DWIDTH-1:0] out_data_o,
  output logic [IDW-1:0]    out_id_o,
  output logic              busy_o
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t            state;
  logic [IDW-1:0]    owner;
  logic [IDW-1:0]    last_owner;
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    nxt_owner;
  logic              found;
  logic [CW-1:0]     cnt;
  logic              issue;
  logic [RD_LAT-1:0] vld_sr;
  logic [IDW-1:0]    id_sr [RD_LAT];

  // Search starts just past the previous owner and wraps, so the lowest offset wins.
  always_comb begin
    cand      = last_owner;
    nxt_owner = last_owner;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (req_i[cand] && !found) begin
        nxt_owner = cand;
        found     = 1'b1;
      end
    end
  end

  assign issue       = ~rrst & (state == ST_BURST) & req_i[owner] & ~fifo_empty_i;
  assign fifo_rinc_o = issue;
  assign gnt_o       = (~rrst && state == ST_BURST) ? (NREQ'(1) << owner) : '0;
  assign busy_o      = ~rrst & ((state == ST_BURST) | (|vld_sr) | out_valid_o);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= ST_IDLE;
      owner      <= '0;
      cnt        <= '0;
      last_owner <= IDW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            owner <= nxt_owner;
            cnt   <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue)
            cnt <= cnt + CW'(1);
          if (!req_i[owner] || (issue && cnt == CW'(BURST - 1))) begin
            state      <= ST_IDLE;
            last_owner <= owner;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Return path: tags ride alongside the read latency; reset drops anything in flight.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      vld_sr      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= '0;
      for (int i = 0; i < RD_LAT; i++)
        id_sr[i] <= '0;
    end else begin
      vld_sr[0] <= issue;
      id_sr[0]  <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
      out_valid_o <= vld_sr[RD_LAT-1];
      if (vld_sr[RD_LAT-1]) begin
        out_data_o <= fifo_rdata_i;
        out_id_o   <= id_sr[RD_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Scoreboard bench: per-cycle rinc/grant vectors and returned-word queues checked by negedge monitors.
module tb_fifo_read_arbiter;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic       rrst, force_empty, fifo_empty, rinc, out_valid, busy;
  logic [3:0] req, gnt;
  logic [7:0] rdata, out_data;
  logic [1:0] out_id;

  logic       r2_rrst, r2_empty, r2_rinc, r2_vld, r2_busy;
  logic [3:0] r2_req, r2_gnt;
  logic [7:0] r2_rdata, r2_data;
  logic [1:0] r2_id;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int fcnt  = 0;
  int c_iss;
  logic rinc_seen = 1'b0;
  logic [7:0] fq [$];

  typedef struct packed {logic rinc; logic [3:0] gnt; logic chk_busy; logic busy;} cexp_t;
  typedef struct packed {logic [7:0] d; logic [1:0] id;} oexp_t;
  cexp_t exp_q [$];
  oexp_t sb [$];
  int    iss_q [$];
  cexp_t ce;
  oexp_t oe;

  assign fifo_empty = force_empty | (fcnt == 0);

  fifo_read_arbiter #(.NREQ(4), .DWIDTH(8), .BURST(4), .RD_LAT(1)) u_dut (
    .rclk(rclk), .rrst(rrst), .req_i(req), .fifo_empty_i(fifo_empty), .fifo_rdata_i(rdata),
    .fifo_rinc_o(rinc), .gnt_o(gnt), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_id_o(out_id), .busy_o(busy));

  fifo_read_arbiter #(.NREQ(4), .DWIDTH(8), .BURST(4), .RD_LAT(3)) u_lat3 (
    .rclk(rclk), .rrst(r2_rrst), .req_i(r2_req), .fifo_empty_i(r2_empty), .fifo_rdata_i(r2_rdata),
    .fifo_rinc_o(r2_rinc), .gnt_o(r2_gnt), .out_valid_o(r2_vld), .out_data_o(r2_data),
    .out_id_o(r2_id), .busy_o(r2_busy));

  always @(posedge rclk) cyc_n <= cyc_n + 1;

  // FIFO model with one cycle read latency: the word popped by a rinc shows up next cycle.
  always @(negedge rclk) rinc_seen = rinc;
  always @(posedge rclk) begin
    #1;
    if (rinc_seen) begin
      if (fq.size() > 0) rdata = fq.pop_front();
      rinc_seen = 1'b0;
      fcnt = fq.size();
    end
  end

  always @(negedge rclk) begin
    if (rinc === 1'b1) iss_q.push_back(cyc_n);
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      total++;
      if (rinc !== ce.rinc || gnt !== ce.gnt) begin
        bad++;
        $display("FAIL rinc_gnt cyc=%0d got rinc=%b gnt=%b want rinc=%b gnt=%b",
                 cyc_n, rinc, gnt, ce.rinc, ce.gnt);
      end
      if (ce.chk_busy) begin
        total++;
        if (busy !== ce.busy) begin
          bad++;
          $display("FAIL busy cyc=%0d got %b want %b", cyc_n, busy, ce.busy);
        end
      end
    end
    if (out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected cyc=%0d got data=%h id=%0d want none", cyc_n, out_data, out_id);
      end else begin
        oe = sb.pop_front();
        if (out_data !== oe.d || out_id !== oe.id) begin
          bad++;
          $display("FAIL out_word cyc=%0d got data=%h id=%0d want data=%h id=%0d",
                   cyc_n, out_data, out_id, oe.d, oe.id);
        end
      end
      total++;
      if (iss_q.size() == 0) begin
        bad++;
        $display("FAIL out_latency cyc=%0d got output with no rinc want rinc 2 cycles earlier", cyc_n);
      end else begin
        c_iss = iss_q.pop_front();
        if (cyc_n != c_iss + 2) begin
          bad++;
          $display("FAIL out_latency got cyc=%0d want cyc=%0d", cyc_n, c_iss + 2);
        end
      end
    end
    if (r2_vld === 1'b1) begin
      total++;
      bad++;
      $display("FAIL lat3_out got out_valid=1 data=%h want no output", r2_data);
    end
  end

  task automatic cycb(input logic [3:0] rq, input logic fe, input logic er, input logic [3:0] eg,
                      input logic cb, input logic eb);
    cexp_t e;
    req = rq;
    force_empty = fe;
    e.rinc = er; e.gnt = eg; e.chk_busy = cb; e.busy = eb;
    exp_q.push_back(e);
    @(posedge rclk); #1;
  endtask

  task automatic cyc(input logic [3:0] rq, input logic fe, input logic er, input logic [3:0] eg);
    cycb(rq, fe, er, eg, 1'b0, 1'b0);
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    fcnt = fq.size();
  endtask

  task automatic expect_out(input logic [7:0] base, input int n, input logic [1:0] id);
    oexp_t o;
    for (int i = 0; i < n; i++) begin
      o.d = base + 8'(i);
      o.id = id;
      sb.push_back(o);
    end
  endtask

  initial begin
    rrst = 1'b1; req = 4'b1111; force_empty = 1'b0; rdata = 8'h00;
    r2_rrst = 1'b1; r2_req = 4'b0000; r2_empty = 1'b0; r2_rdata = 8'hA5;
    fill(8'h20, 16);
    @(posedge rclk); #1;

    // Reset held with all requests up and a non-empty FIFO.
    repeat (3) cycb(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    rrst = 1'b0;

    // Round robin 0,2,0,2 with an idle cycle between bursts.
    expect_out(8'h20, 4, 2'd0); expect_out(8'h24, 4, 2'd2);
    expect_out(8'h28, 4, 2'd0); expect_out(8'h2C, 4, 2'd2);
    for (int b = 0; b < 4; b++) begin
      cyc(4'b0101, 1'b0, 1'b0, 4'b0000);
      cycb(4'b0101, 1'b0, 1'b1, (b % 2 == 0) ? 4'b0001 : 4'b0100, 1'b1, 1'b1);
      repeat (3) cyc(4'b0101, 1'b0, 1'b1, (b % 2 == 0) ? 4'b0001 : 4'b0100);
    end
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Single requester: 4-word burst, idle, 2 words, FIFO runs dry, request drops.
    fill(8'h10, 6);
    expect_out(8'h10, 6, 2'd0);
    cyc(4'b0001, 1'b0, 1'b0, 4'b0000);
    repeat (4) cyc(4'b0001, 1'b0, 1'b1, 4'b0001);
    cyc(4'b0001, 1'b0, 1'b0, 4'b0000);
    repeat (2) cyc(4'b0001, 1'b0, 1'b1, 4'b0001);
    cyc(4'b0001, 1'b0, 1'b0, 4'b0001);
    cycb(4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1);
    cycb(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Empty stall for owner 1 at cnt=2.
    fill(8'h30, 4);
    expect_out(8'h30, 4, 2'd1);
    cyc(4'b0010, 1'b0, 1'b0, 4'b0000);
    repeat (2) cyc(4'b0010, 1'b0, 1'b1, 4'b0010);
    repeat (3) cyc(4'b0010, 1'b1, 1'b0, 4'b0010);
    repeat (2) cyc(4'b0010, 1'b0, 1'b1, 4'b0010);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Owner 3 drops after 2 words; next search wraps to index 0 and picks 1.
    fill(8'h40, 4);
    expect_out(8'h40, 2, 2'd3); expect_out(8'h42, 2, 2'd1);
    cyc(4'b1000, 1'b0, 1'b0, 4'b0000);
    repeat (2) cyc(4'b1000, 1'b0, 1'b1, 4'b1000);
    cyc(4'b0000, 1'b0, 1'b0, 4'b1000);
    cyc(4'b0110, 1'b0, 1'b0, 4'b0000);
    repeat (2) cyc(4'b0110, 1'b0, 1'b1, 4'b0010);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0010);
    cycb(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    cycb(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    repeat (2) cyc(4'b0000, 1'b0, 1'b0, 4'b0000);

    total++;
    if (sb.size() != 0 || iss_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending_words=%0d pending_rincs=%0d want 0/0", sb.size(), iss_q.size());
    end

    // RD_LAT=3 instance: rinc at t, reset at t+1, no word may come back.
    r2_rrst = 1'b0; r2_req = 4'b0001;
    @(posedge rclk); #1;
    @(negedge rclk);
    total++;
    if (r2_rinc !== 1'b1 || r2_gnt !== 4'b0001) begin
      bad++;
      $display("FAIL lat3_issue got rinc=%b gnt=%b want rinc=1 gnt=0001", r2_rinc, r2_gnt);
    end
    @(posedge rclk); #1;
    r2_rrst = 1'b1; r2_req = 4'b0000;
    @(posedge rclk); #1;
    r2_rrst = 1'b0;
    repeat (5) begin
      @(negedge rclk);
      total++;
      if (r2_busy !== 1'b0) begin
        bad++;
        $display("FAIL lat3_busy got %b want 0", r2_busy);
      end
      @(posedge rclk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/fifo_read_arbiter.md
Name: fifo_read_arbiter

Overview:
- Read-side scheduler for the FIFO read port. Shares one FIFO output among NREQ consumers and runs in the read clock domain.
- Grants the port round-robin in bursts of up to BURST words. Drives the FIFO read increment and tags each returned word with the owning requester ID.
- Sits between the read-pointer/empty logic plus read memory on one side and the consumer blocks on the other.

Parameters:
- NREQ, 4: number of requesters (2..16).
- DWIDTH, 8: FIFO data width.
- BURST, 4: maximum words per grant (>=1).
- RD_LAT, 1: cycles from fifo_rinc_o high to valid fifo_rdata_i (>=1).
- IDW, $clog2(NREQ): requester ID width.

Ports:
- rclk  in  1  read-domain clock, rising edge.
- rrst  in  1  synchronous, active-high reset.
- req_i  in  NREQ  per-requester read request, level. Held while the requester wants more words.
- fifo_empty_i  in  1  FIFO empty flag. When low, at least one word is readable this cycle (FIFO-side guarantee).
- fifo_rdata_i  in  DWIDTH  FIFO read data, valid RD_LAT cycles after each rinc.
- fifo_rinc_o  out  1  read increment, one word per high cycle.
- gnt_o  out  NREQ  one-hot current owner; all zero when idle.
- out_valid_o  out  1  returned-word strobe.
- out_data_o  out  DWIDTH  returned word.
- out_id_o  out  IDW  owner index of the returned word.
- busy_o  out  1  high in BURST state or while any word is in flight.

Behaviour:
- Reset (rrst high at a rising edge):
  - state=IDLE, owner=0, cnt=0, last_owner=NREQ-1.
  - In-flight pipeline cleared; in-flight words are dropped, not delivered.
  - All outputs 0.
- FSM states: IDLE, BURST.
- IDLE:
  - fifo_rinc_o=0, gnt_o=0.
  - If any req_i bit is high, select the first requester searching from (last_owner+1) mod NREQ upward with wrap. Register it as owner, cnt=0, go to BURST.
  - fifo_empty_i does not gate arbitration.
- BURST:
  - gnt_o = one-hot(owner).
  - issue = req_i[owner] & ~fifo_empty_i; fifo_rinc_o = issue (combinational).
  - On issue, cnt increments.
  - Exit to IDLE with last_owner=owner when either:
    - issue and cnt==BURST-1 (burst complete), or
    - req_i[owner]==0 (request dropped; no rinc that cycle).
  - Otherwise stay in BURST.
  - fifo_empty_i high with req_i[owner] high: stall with no rinc and keep the grant. No timeout.
- Rearbitration costs one IDLE cycle. Peak throughput is BURST words per BURST+1 cycles.
- Requests from non-owners are ignored until the next IDLE. Requests are never queued.
- Return path:
  - Shift register of depth RD_LAT carries {valid, owner} from each issue.
  - At rinc cycle t, fifo_rdata_i is sampled at t+RD_LAT.
  - out_valid_o, out_data_o and out_id_o are registered, high for exactly one cycle at t+RD_LAT+1.
  - Order equals issue order.
  - out_data_o and out_id_o hold their last value when out_valid_o is low.
- busy_o = (state==BURST) | any valid bit in the shift register | out_valid_o.
- cnt width is $clog2(BURST+1). With BURST=1, every granted read returns to IDLE.
- Reset mid-burst or with words in flight: synchronous clear at the next edge. No out_valid_o pulses after reset deasserts for reads issued before reset.

Test Plan:
- Reset: hold rrst 3 cycles with req_i=4'b1111 and FIFO non-empty -> fifo_rinc_o, gnt_o, out_valid_o and busy_o all 0 throughout. After release, owner 0 is granted first.
- Single requester:
  - Stimulus: req_i=0001, FIFO holds words 0x10..0x15, BURST=4, RD_LAT=1.
  - Rinc pattern: 1,1,1,1,0(IDLE),1,1.
  - out_valid_o carries 0x10..0x15 with ID 0, each 2 cycles after its rinc.
- Round robin: req_i=0101 held, FIFO full -> grant order 0,2,0,2 with 4 words each and one idle cycle between bursts. out_id_o sequence matches.
- Empty stall:
  - Stimulus: owner 1 mid-burst at cnt=2, fifo_empty_i high for 3 cycles.
  - Required: rinc low for those 3 cycles, gnt_o stays 0010. Remaining 2 words are issued after empty deasserts, then IDLE.
- Request drop: owner 3 deasserts req_i[3] after 2 words -> no rinc that cycle, IDLE next. The next grant searches from index 0 with wrap.
- Reset in flight: RD_LAT=3, rinc issued at cycle t, rrst pulsed at t+1 -> no out_valid_o at t+4, busy_o=0 after reset.
